// File: rtl/rx_fifo.sv
// rx_fifo: 2**AW x 8 first-word-fall-through receive FIFO.
// Ports: din/din_rdy in, rd pop, ovr_clr; dout, empty, full, count, irq, overrun.
module rx_fifo #(
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_rdy,
  input  logic        rd,
  input  logic        ovr_clr,
  output logic [7:0]  dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        irq,
  output logic        overrun
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_C = DEPTH[AW:0];
  localparam logic [AW:0] THR_C  = THRESH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          ovr;
  logic          pop;
  logic          wr;
  logic          drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_C);
  assign irq   = (cnt >= THR_C);
  assign count = cnt;
  assign overrun = ovr;
  assign dout  = empty ? 8'h00 : mem[rp];

  // A pop frees a slot on the same edge, so a full FIFO
  // can still accept a byte when the consumer reads.
  assign pop  = rd & ~empty;
  assign wr   = din_rdy & (~full | pop);
  assign drop = din_rdy & ~wr;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovr <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      unique case (1'b1)
        wr & ~pop: cnt <= cnt + 1'b1;
        pop & ~wr: cnt <= cnt - 1'b1;
        default:   cnt <= cnt;
      endcase
      if (drop)         ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed and random checks of rx_fifo
// against a queue-based reference model.
module tb_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_rdy;
  logic       rd;
  logic       ovr_clr;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       irq;
  logic       overrun;

  int n_chk;
  int n_fail;
  logic [7:0] q[$];
  bit ov;

  rx_fifo #(.AW(4), .THRESH(8)) dut (
    .clk(clk), .rst(rst), .din(din),
    .din_rdy(din_rdy), .rd(rd), .ovr_clr(ovr_clr),
    .dout(dout), .empty(empty), .full(full),
    .count(count), .irq(irq), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mcheck();
    logic [7:0] h;
    h = (q.size() > 0) ? q[0] : 8'h00;
    chk("m_count", 32'(count), q.size());
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_full", 32'(full), 32'(q.size() == 16));
    chk("m_irq", 32'(irq), 32'(q.size() >= 8));
    chk("m_ovr", 32'(overrun), 32'(ov));
    chk("m_dout", 32'(dout), 32'(h));
  endtask

  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r, input logic c);
    bit p;
    bit a;
    din_rdy = w;
    din = d;
    rd = r;
    ovr_clr = c;
    p = r && (q.size() > 0);
    a = w && ((q.size() < 16) || p);
    @(posedge clk);
    #1;
    if (p) void'(q.pop_front());
    if (a) q.push_back(d);
    if (w && !a) ov = 1;
    else if (c) ov = 0;
    din_rdy = 0;
    rd = 0;
    ovr_clr = 0;
    mcheck();
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(0, 8'h00, 1, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    ov = 0;
    rst = 0;
    din = 0;
    din_rdy = 0;
    rd = 0;
    ovr_clr = 0;
    #2;
    mcheck();
    #1 rst = 1;

    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h3C, 0, 0);
    chk("two_dout", 32'(dout), 32'hA5);
    chk("two_cnt", 32'(count), 2);
    cyc(0, 8'h00, 1, 0);
    chk("pop_dout", 32'(dout), 32'h3C);
    chk("pop_cnt", 32'(count), 1);
    drain();

    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    cyc(1, 8'hFF, 0, 0);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_cnt", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_seq", 32'(dout), i);
      cyc(0, 8'h00, 1, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    cyc(1, 8'h11, 0, 1);
    chk("ovr_clr", 32'(overrun), 0);
    drain();

    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    cyc(1, 8'h77, 1, 0);
    chk("fullrw_cnt", 32'(count), 16);
    chk("fullrw_ovr", 32'(overrun), 0);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
    chk("last_77", 32'(dout), 32'h77);
    cyc(0, 8'h00, 1, 0);
    chk("after_77", 32'(empty), 1);

    cyc(0, 8'h00, 1, 0);
    chk("rd_empty_cnt", 32'(count), 0);
    chk("rd_empty_ovr", 32'(overrun), 0);
    cyc(1, 8'h5A, 1, 0);
    chk("emptyrw_cnt", 32'(count), 1);
    chk("emptyrw_dout", 32'(dout), 32'h5A);
    drain();

    for (int i = 0; i < 7; i++) cyc(1, 8'(i + 8'h40), 0, 0);
    chk("irq_7", 32'(irq), 0);
    cyc(1, 8'h47, 0, 0);
    chk("irq_8", 32'(irq), 1);
    cyc(0, 8'h00, 1, 0);
    chk("irq_back7", 32'(irq), 0);
    drain();
    for (int i = 0; i < 20; i++)
      cyc(1, 8'($urandom), ($urandom_range(0, 1) == 1), 0);
    drain();

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 2) != 0), 8'($urandom),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 15) == 0));
    drain();
    cyc(0, 8'h00, 0, 1);

    for (int i = 0; i < 16; i++) cyc(1, 8'(i + 8'h80), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 8'h00, 1, 0);
    chk("pre_rst_cnt", 32'(count), 5);
    chk("pre_rst_ovr", 32'(overrun), 1);
    #2 rst = 0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_dout", 32'(dout), 0);
    q.delete();
    ov = 0;
    #2 rst = 1;
    cyc(1, 8'hC3, 0, 0);
    chk("post_rst_dout", 32'(dout), 32'hC3);
    chk("post_rst_cnt", 32'(count), 1);
    cyc(1, 8'h96, 1, 0);
    chk("post_rst_2", 32'(dout), 32'h96);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning address width; depth = 2**AW entries.
REQ-002 The block SHALL have parameter THRESH, default 8, meaning the fill-level threshold for irq, legal range 1..2**AW.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port din, input, 8 bits, the received byte from the receiver stage.
REQ-006 The block SHALL have port din_rdy, input, 1 bit, a one-cycle strobe qualifying din.
REQ-007 The block SHALL have port rd, input, 1 bit, the pop request from the consumer.
REQ-008 The block SHALL have port ovr_clr, input, 1 bit, which clears the overrun flag.
REQ-009 The block SHALL have port dout, output, 8 bits, the head entry (first-word-fall-through).
REQ-010 The block SHALL have port empty, output, 1 bit, meaning count == 0.
REQ-011 The block SHALL have port full, output, 1 bit, meaning count == 2**AW.
REQ-012 The block SHALL have port count, output, AW+1 bits, the number of stored entries.
REQ-013 The block SHALL have port irq, output, 1 bit, meaning count >= THRESH.
REQ-014 The block SHALL have port overrun, output, 1 bit, a sticky flag for a dropped byte.

Function
REQ-015 Storage SHALL be 2**AW x 8 registers with AW-bit write and read pointers that wrap from 2**AW-1 to 0.
REQ-016 A write SHALL occur on the rising edge where din_rdy=1 and (full=0 or a pop occurs in the same cycle): mem[wp] <= din, wp <= wp+1.
REQ-017 A pop SHALL occur on the rising edge where rd=1 and empty=0: rp <= rp+1.
REQ-018 When rd=1 and empty=1, the read SHALL be ignored, with no pointer or count change and no error flag.
REQ-019 count SHALL update on the same edge as write/pop: +1 for write only, -1 for pop only, unchanged for both or neither.
REQ-020 When the FIFO is empty and din_rdy and rd are both 1, the write SHALL proceed and the pop SHALL be ignored (count becomes 1).
REQ-021 When the FIFO is full and din_rdy and rd are both 1, both the pop and the write SHALL proceed, count SHALL stay 2**AW, and overrun SHALL not set.
REQ-022 When the FIFO is full, din_rdy=1 and rd=0, the byte SHALL be discarded, the stored contents SHALL be unchanged, and overrun SHALL be set to 1 on that edge.
REQ-023 overrun SHALL remain 1 until an edge with ovr_clr=1; if a set condition and ovr_clr coincide, set SHALL win.
REQ-024 dout SHALL equal mem[rp] while empty=0 and SHALL be 8'h00 while empty=1; no extra register stage is added.
REQ-025 Write-to-visible latency SHALL be 1 clock: the byte written at edge N appears on dout and empty falls after edge N, when the FIFO was empty.
REQ-026 empty, full and irq SHALL be decoded from the registered count only, with no dependence on same-cycle inputs.

Reset
REQ-027 When rst=0, the block SHALL asynchronously force wp=0, rp=0, count=0 and overrun=0, giving empty=1, full=0, irq=0 and dout=8'h00.
REQ-028 Memory contents SHALL not be reset, and no output may expose them while empty=1.
REQ-029 Reset assertion mid-operation SHALL discard all stored bytes; the first write after rst rises SHALL land at address 0.

Verification
REQ-030 The bench SHALL write 8'hA5 then 8'h3C with no reads and check that dout=8'hA5 and count=2 one cycle after the second strobe, and that after one rd, dout=8'h3C and count=1.
REQ-031 The bench SHALL fill 16 bytes 8'h00..8'h0F (AW=4) and check full=1; it SHALL then strobe din=8'hFF and check overrun=1, count=16, and that draining yields exactly 00..0F with empty=1 at the end.
REQ-032 With the FIFO full, the bench SHALL apply din_rdy=1 (din=8'h77) and rd=1 in the same cycle, and check count=16, overrun=0, and that 8'h77 is the last byte drained.
REQ-033 With the FIFO empty, the bench SHALL apply rd=1 alone, check that there is no change, then apply din_rdy=1 (din=8'h5A) and rd=1 together, and check count=1 and dout=8'h5A.
REQ-034 The bench SHALL check that irq rises on the write taking count 7->8 and falls on the pop taking count 8->7; it SHALL then write 20 bytes interleaved with reads to cross the pointer wrap and check data order is preserved.
REQ-035 The bench SHALL assert rst=0 asynchronously between clock edges with count=5 and overrun=1, and check that empty=1, count=0, overrun=0 and dout=8'h00 immediately, before the next edge.
